// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants, instruction field positions and fetch state type
package cpu_defs_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   // Instruction field positions used by the decoder
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int COND_MSB = 11;
   localparam int COND_LSB = 9;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_CMP  = 4'hB;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_JAL  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_EXEC = 4'hF;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // Next sequential word address, wrapping at the top of the address space
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry {instr, pc} holding register behind the IF/ID register
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   wr              capture wr_instr/wr_pc and mark full
//   rd              consume the held entry (clears full)
//   flush           discard the held entry; wins over wr and rd
//   wr_instr/wr_pc  entry being captured
//   full            entry held
//   instr/pc        held entry
module if_skid_buffer
   import cpu_defs_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rd,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_instr,
   input  logic [ADDR_W-1:0] wr_pc,
   output logic              full,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full  <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (wr) begin
         full  <= 1'b1;
         instr <= wr_instr;
         pc    <= wr_pc;
      end else if (rd) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem fetch, IF/ID register with skid
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   imem_req, imem_addr           registered one-cycle fetch request and word address
//   imem_rvalid, imem_rdata       fetch response
//   stall                         downstream holds IF/ID
//   redirect_valid, redirect_pc   branch/JAL/JR target; highest priority
//   if_valid, if_instr, if_pc     IF/ID register contents
//   if_pc_next                    if_pc + 1 (JAL link value)
//   opcode, cond                  decoder slices of if_instr
module fetch_unit
   import cpu_defs_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_next,
   output logic [3:0]        opcode,
   output logic [2:0]        cond
);

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic              discard;

   logic              skid_full;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;

   logic              issue;
   logic              resp;
   logic              resp_to_ifid;
   logic              resp_to_skid;
   logic              skid_to_ifid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      issue        = 1'b0;
      resp         = 1'b0;
      resp_to_ifid = 1'b0;
      resp_to_skid = 1'b0;
      skid_to_ifid = 1'b0;

      case (state)
         FETCH: begin
            // A full skid means IF/ID is also occupied; fetching more would have nowhere to land.
            if (!skid_full && !redirect_valid) begin
               issue     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               resp      = !redirect_valid && !discard;
               state_nxt = FETCH;
            end else if (redirect_valid) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase

      // Steering into IF/ID: the skid entry is older than any response, so it goes first.
      if (!stall) begin
         if (skid_full) begin
            skid_to_ifid = 1'b1;
         end else if (resp) begin
            resp_to_ifid = 1'b1;
         end
      end else if (resp) begin
         if (if_valid) begin
            resp_to_skid = 1'b1;
         end else begin
            resp_to_ifid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         req_pc     <= '0;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         discard    <= 1'b0;
         if_valid   <= 1'b0;
         if_instr   <= '0;
         if_pc      <= '0;
         if_pc_next <= '0;
      end else begin
         imem_req <= issue;
         discard  <= (state_nxt == DRAIN);

         if (issue) begin
            imem_addr <= fetch_pc;
            req_pc    <= fetch_pc;
         end

         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
         end else if (issue) begin
            fetch_pc <= pc_inc(fetch_pc);
         end

         if (redirect_valid) begin
            if_valid <= 1'b0;
         end else if (skid_to_ifid) begin
            if_valid   <= 1'b1;
            if_instr   <= skid_instr;
            if_pc      <= skid_pc;
            if_pc_next <= pc_inc(skid_pc);
         end else if (resp_to_ifid) begin
            if_valid   <= 1'b1;
            if_instr   <= imem_rdata;
            if_pc      <= req_pc;
            if_pc_next <= pc_inc(req_pc);
         end else if (!stall) begin
            if_valid <= 1'b0;
         end
      end
   end

   if_skid_buffer u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (resp_to_skid),
      .rd       (skid_to_ifid),
      .flush    (redirect_valid),
      .wr_instr (imem_rdata),
      .wr_pc    (req_pc),
      .full     (skid_full),
      .instr    (skid_instr),
      .pc       (skid_pc)
   );

   assign opcode = if_instr[OPC_MSB:OPC_LSB];
   assign cond   = if_instr[COND_MSB:COND_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   import cpu_defs_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_next;
   logic [3:0]  opcode;
   logic [2:0]  cond;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_next     (if_pc_next),
      .opcode         (opcode),
      .cond           (cond)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   int          lat      = 1;
   bit          rand_lat = 1'b0;
   int          pend     = 0;
   logic [15:0] pend_addr;
   int          stray    = 0;

   logic [15:0] exp_pc;
   logic [15:0] exp_req;
   int          req_count = 0;
   int          consumed  = 0;
   int          idle      = 0;
   bit          prev_redirect = 1'b0;
   bit          prev_hold     = 1'b0;
   logic [15:0] prev_pc;
   logic [15:0] prev_instr;
   int          first_req_cyc   = -1;
   int          first_valid_cyc = -1;
   int          r0;

   function automatic logic [15:0] word(input logic [15:0] a);
      return {a[3:0], 12'h000} ^ {4'h0, a[15:4]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_imem_req"},   imem_req,   0);
      check({tag, "_imem_addr"},  imem_addr,  0);
      check({tag, "_if_valid"},   if_valid,   0);
      check({tag, "_if_instr"},   if_instr,   0);
      check({tag, "_if_pc"},      if_pc,      0);
      check({tag, "_if_pc_next"}, if_pc_next, 0);
      check({tag, "_opcode"},     opcode,     0);
      check({tag, "_cond"},       cond,       0);
   endtask

   // One clock cycle: drive inputs, play memory, then check IF/ID against the program-order model.
   task automatic cycle(input bit st, input bit rd, input logic [15:0] rpc);
      logic [15:0] w;
      logic [15:0] nx;
      stall          = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_rvalid    = 1'b0;
      imem_rdata     = 16'($urandom);
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend_addr);
         end
      end
      if (stray > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 16'hBEEF;
         stray--;
      end
      if (!rst_n) begin
         pend = 0;
      end else if (imem_req === 1'b1) begin
         if (pend != 0) check("one_outstanding", pend, 0);
         check("req_addr", imem_addr, exp_req);
         exp_req = exp_req + 16'd1;
         req_count++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
         pend_addr = imem_addr;
         if (rand_lat) lat = $urandom_range(4, 1);
         pend = lat;
      end

      @(negedge clk);
      if (!rst_n) begin
         exp_pc        = RESET_PC;
         exp_req       = RESET_PC;
         prev_redirect = 1'b0;
         prev_hold     = 1'b0;
      end else begin
         if (prev_redirect) check("flush_after_redirect", if_valid, 0);
         if (prev_hold) begin
            check("hold_valid", if_valid, 1);
            check("hold_pc", if_pc, prev_pc);
            check("hold_instr", if_instr, prev_instr);
         end
         if (if_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (if_valid === 1'b1 && !st && !rd) begin
            w  = word(exp_pc);
            nx = exp_pc + 16'd1;
            check("if_pc", if_pc, exp_pc);
            check("if_instr", if_instr, w);
            check("if_pc_next", if_pc_next, nx);
            check("opcode", opcode, w[15:12]);
            check("cond", cond, w[11:9]);
            exp_pc = nx;
            consumed++;
            idle = 0;
         end else if (!st && !rd) begin
            idle++;
            if (idle == 25) check("progress_watchdog", idle, 0);
         end
         if (rd) begin
            exp_pc  = rpc;
            exp_req = rpc;
            idle    = 0;
         end
         prev_redirect = rd;
         prev_hold     = st && (if_valid === 1'b1) && !rd;
         prev_pc       = if_pc;
         prev_instr    = if_instr;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 16'h0;
      exp_pc         = RESET_PC;
      exp_req        = RESET_PC;
      #1;
      repeat (2) cycle(0, 0, 16'h0);
      reset_checks("por");

      // Sequential fetch with latency 1
      lat   = 1;
      rst_n = 1'b1;
      for (int i = 0; i < 20 && if_valid !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("first_pc", if_pc, 16'h0000);
      check("first_opcode", opcode, OP_ADD);

      // Stall 6 cycles: pc 0 held, pc 1 parked in skid, no further fetch
      r0 = req_count;
      repeat (6) cycle(1, 0, 16'h0);
      check("first_latency", first_valid_cyc - first_req_cyc, 2);
      check("stall_reqs", req_count - r0, 1);
      cycle(0, 0, 16'h0);
      check("skid_valid", if_valid, 1);
      check("skid_pc", if_pc, 16'h0001);

      // Redirect while the request to 3 is outstanding (latency 3)
      lat = 3;
      for (int i = 0; i < 30 && !(imem_req === 1'b1 && imem_addr === 16'h0003); i++) cycle(0, 0, 16'h0);
      check("saw_req3", imem_addr, 16'h0003);
      cycle(0, 0, 16'h0);
      cycle(0, 1, 16'h0040);
      check("redir_flush", if_valid, 0);
      for (int i = 0; i < 20 && imem_req !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("redir_addr", imem_addr, 16'h0040);
      lat = 1;
      for (int i = 0; i < 20 && if_valid !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("redir_pc", if_pc, 16'h0040);

      // Redirect + stall with IF/ID and skid both occupied
      repeat (6) cycle(1, 0, 16'h0);
      cycle(1, 1, 16'h0100);
      check("flush_both_valid", if_valid, 0);
      for (int i = 0; i < 20 && if_valid !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("restart_pc", if_pc, 16'h0100);

      // Wrap from 16'hFFFF to 16'h0000
      cycle(0, 1, 16'hFFFF);
      for (int i = 0; i < 20 && if_valid !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("wrap_pc", if_pc, 16'hFFFF);
      check("wrap_pc_next", if_pc_next, 16'h0000);
      cycle(0, 0, 16'h0);
      for (int i = 0; i < 20 && if_valid !== 1'b1; i++) cycle(0, 0, 16'h0);
      check("wrap_next_pc", if_pc, 16'h0000);

      // Randomized traffic against the program-order model
      rand_lat = 1'b1;
      repeat (1500) begin
         cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4, 16'($urandom));
      end
      check("random_progress", consumed > 150, 1);

      // Reset in the middle of WAIT with stray responses around release
      rand_lat = 1'b0;
      lat      = 3;
      for (int i = 0; i < 30 && imem_req !== 1'b1; i++) cycle(0, 0, 16'h0);
      cycle(0, 0, 16'h0);
      rst_n = 1'b0;
      stray = 3;
      repeat (2) cycle(0, 0, 16'h0);
      reset_checks("mid");
      rst_n = 1'b1;
      lat   = 1;
      cycle(0, 0, 16'h0);
      check("stray_ignored", if_valid, 0);
      check("reset_req", imem_req, 1);
      check("reset_addr", imem_addr, RESET_PC);
      repeat (12) cycle(0, 0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
